crack_scheduler: RTL

CRACK_SCHEDULER -- requirements
Module: crack_scheduler

---
 rtl/crack_pkg.sv | 21 ++
 rtl/crack_scheduler_rr_grant.sv | 39 +++
 rtl/crack_scheduler.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/crack_pkg.sv
// Shared types and constants for the password-search scheduler.
// Holds the FSM state encoding, width defaults and printable-ASCII bounds.
package crack_pkg;

  localparam int NUM_WORKERS_DEF = 4;
  localparam int PW_W_DEF        = 128;
  localparam int CNT_W_DEF       = 32;

  // Printable ASCII range that the brute-force workers walk through.
  localparam logic [7:0] ASCII_FIRST = 8'h20;
  localparam logic [7:0] ASCII_LAST  = 8'h7E;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONFIG,
    ST_RUN,
    ST_FOUND,
    ST_EXHAUSTED
  } state_e;

endpackage

// File: rtl/crack_scheduler_rr_grant.sv
// Round-robin one-hot grant generator: the pointer advances one worker per
// enabled cycle and returns to worker 0 whenever clear is asserted.
module rr_grant #(
  parameter int N = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         enable,
  input  logic         clear,
  output logic [N-1:0] grant,
  output logic [2:0]   ptr
);

  logic [2:0] ptr_q;
  logic [2:0] ptr_d;

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    ptr_d = ptr_q;
    if (clear) begin
      ptr_d = '0;
    end else if (enable) begin
      ptr_d = (ptr_q == 3'(N - 1)) ? 3'd0 : ptr_q + 3'd1;
    end
    grant = enable ? (N'(1) << ptr_q) : '0;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/crack_scheduler.sv
// Brute-force search scheduler: configures the workers, grants them round-robin,
// compares each granted password to the target and reports match or exhaustion.
module crack_scheduler
  import crack_pkg::*;
#(
  parameter int NUM_WORKERS = NUM_WORKERS_DEF,
  parameter int PW_W        = PW_W_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      abort,
  input  logic [PW_W-1:0]           target,
  input  logic [7:0]                start_base,
  input  logic [CNT_W-1:0]          max_attempts,
  input  logic [NUM_WORKERS*PW_W-1:0] worker_pw,
  output logic                      worker_enable,
  output logic [NUM_WORKERS*8-1:0]  worker_start_pos,
  output logic [NUM_WORKERS*3-1:0]  worker_increment,
  output logic [NUM_WORKERS-1:0]    worker_ready,
  output logic                      busy,
  output logic                      found,
  output logic                      exhausted,
  output logic [PW_W-1:0]           found_password,
  output logic [2:0]                found_worker,
  output logic [CNT_W-1:0]          attempts
);

  state_e                   state_q, state_d;
  logic [PW_W-1:0]          target_q, target_d;
  logic [CNT_W-1:0]         max_q, max_d;
  logic [NUM_WORKERS*8-1:0] pos_q, pos_d;
  logic [NUM_WORKERS*3-1:0] inc_q, inc_d;
  logic [CNT_W-1:0]         attempts_q, attempts_d;
  logic [CNT_W-1:0]         attempts_sat;
  logic [PW_W-1:0]          fpw_q, fpw_d;
  logic [2:0]               fw_q, fw_d;
  logic                     cmp_valid_q, cmp_valid_d;
  logic [PW_W-1:0]          cmp_pw_q, cmp_pw_d;
  logic [2:0]               cmp_tag_q, cmp_tag_d;

  logic                     run_active;
  logic                     rr_clear;
  logic [NUM_WORKERS-1:0]   grant;
  logic [2:0]               grant_idx;

  assign run_active = (state_q == ST_RUN);
  assign rr_clear   = !run_active;

  rr_grant #(
    .N(NUM_WORKERS)
  ) u_rr_grant (
    .clock  (clock),
    .reset  (reset),
    .enable (run_active),
    .clear  (rr_clear),
    .grant  (grant),
    .ptr    (grant_idx)
  );

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    max_d      = max_q;
    pos_d      = pos_q;
    inc_d      = inc_q;
    attempts_d = attempts_q;
    fpw_d      = fpw_q;
    fw_d       = fw_q;

    attempts_sat = (&attempts_q) ? attempts_q : attempts_q + CNT_W'(1);

    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_FOUND, ST_EXHAUSTED: begin
          if (start) begin
            state_d    = ST_CONFIG;
            target_d   = target;
            max_d      = max_attempts;
            attempts_d = '0;
            fpw_d      = '0;
            fw_d       = '0;
            for (int i = 0; i < NUM_WORKERS; i++) begin
              pos_d[i*8 +: 8] = start_base + 8'(i);
              inc_d[i*3 +: 3] = 3'(NUM_WORKERS);
            end
          end
        end
        ST_CONFIG: state_d = ST_RUN;
        ST_RUN: begin
          if (cmp_valid_q) begin
            attempts_d = attempts_sat;
            // A match outranks reaching the limit on the same compare.
            if (cmp_pw_q == target_q) begin
              state_d = ST_FOUND;
              fpw_d   = cmp_pw_q;
              fw_d    = cmp_tag_q;
            end else if ((max_q != '0) && (attempts_sat == max_q)) begin
              state_d = ST_EXHAUSTED;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // A capture survives only if the search is still running next cycle.
    cmp_valid_d = run_active && (state_d == ST_RUN);
    cmp_pw_d    = worker_pw[grant_idx*PW_W +: PW_W];
    cmp_tag_d   = grant_idx;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      target_q    <= '0;
      max_q       <= '0;
      pos_q       <= '0;
      inc_q       <= '0;
      attempts_q  <= '0;
      fpw_q       <= '0;
      fw_q        <= '0;
      cmp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      max_q       <= max_d;
      pos_q       <= pos_d;
      inc_q       <= inc_d;
      attempts_q  <= attempts_d;
      fpw_q       <= fpw_d;
      fw_q        <= fw_d;
      cmp_valid_q <= cmp_valid_d;
    end
  end

  // NOTE: the compare data path is qualified by cmp_valid_q, so it needs no reset.
  always_ff @(posedge clock) begin
    cmp_pw_q  <= cmp_pw_d;
    cmp_tag_q <= cmp_tag_d;
  end

  assign worker_enable    = run_active;
  assign worker_ready     = grant;
  assign worker_start_pos = pos_q;
  assign worker_increment = inc_q;
  assign busy             = (state_q == ST_CONFIG) || run_active;
  assign found            = (state_q == ST_FOUND);
  assign exhausted        = (state_q == ST_EXHAUSTED);
  assign found_password   = fpw_q;
  assign found_worker     = fw_q;
  assign attempts         = attempts_q;

endmodule
